multicore_completion_monitor: RTL and testbench

Synthesizable per-core program-completion monitor for the multi-core processor top level. For each of NUM_CORES cores it detects the end-of-program PC, records the run time in cycles, waits a pipeline-drain interval, then samples the core's result register and grades it pass/fail. Timeout detection and aggregated status let hardware or a bench stop on `all_done`, with no polling of internal signals.

---
 rtl/completion_monitor_pkg.sv | 25 ++
 rtl/core_completion_tracker.sv | 86 ++++++++
 rtl/multicore_completion_monitor.sv | 82 ++++++++
 tb/tb_multicore_completion_monitor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/completion_monitor_pkg.sv
// Shared types and helpers for the multi-core completion monitor.
package completion_monitor_pkg;

    // Per-core lifecycle of one program run.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest core vector the popcount helper accepts.
    localparam int MAX_CORES = 128;

    // Number of set bits; callers zero-extend their vector to MAX_CORES.
    function automatic logic [7:0] popcount(input logic [MAX_CORES-1:0] v);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/core_completion_tracker.sv
// Tracks one core: end-PC detection, drain wait, result grading, timeout.
module core_completion_tracker
    import completion_monitor_pkg::*;
#(
    parameter int                    ADDRESS_BITS = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CYCLE_BITS   = 32,
    parameter int                    DRAIN_CYCLES = 50,
    parameter logic [DATA_WIDTH-1:0] PASS_VALUE   = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] pc,
    input  logic [ADDRESS_BITS-1:0] end_address,
    input  logic [DATA_WIDTH-1:0]   result_reg,
    input  logic [CYCLE_BITS-1:0]   timeout_limit,
    input  logic [CYCLE_BITS-1:0]   elapsed_inc,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic                    done_pulse,
    output logic [CYCLE_BITS-1:0]   cycle_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

    state_t             state;
    logic [DRAIN_W-1:0] drain_cnt;

    // Run FSM; start from any state restarts the run and clears the status.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            cycle_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (start) begin
                state       <= RUN;
                drain_cnt   <= '0;
                cycle_count <= '0;
                done        <= 1'b0;
                pass        <= 1'b0;
                timeout     <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        // A PC match on the timeout edge still counts as a finish.
                        if (pc == end_address) begin
                            cycle_count <= elapsed_inc;
                            drain_cnt   <= DRAIN_LOAD;
                            state       <= DRAIN;
                        end else if (timeout_limit != '0 && elapsed_inc == timeout_limit) begin
                            cycle_count <= timeout_limit;
                            done        <= 1'b1;
                            timeout     <= 1'b1;
                            pass        <= 1'b0;
                            done_pulse  <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    DRAIN: begin
                        // Grade on the edge where the counter would reach zero.
                        if (drain_cnt == DRAIN_W'(1)) begin
                            drain_cnt  <= '0;
                            pass       <= (result_reg == PASS_VALUE);
                            done       <= 1'b1;
                            done_pulse <= 1'b1;
                            state      <= DONE;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/multicore_completion_monitor.sv
// Per-core program completion monitor with shared run clock and aggregate status.
module multicore_completion_monitor
    import completion_monitor_pkg::*;
#(
    parameter int                    NUM_CORES    = 2,
    parameter int                    ADDRESS_BITS = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CYCLE_BITS   = 32,
    parameter int                    DRAIN_CYCLES = 50,
    parameter logic [DATA_WIDTH-1:0] PASS_VALUE   = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0]  PC,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0]  end_address,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]    result_reg,
    input  logic [CYCLE_BITS-1:0]              timeout_limit,
    output logic [NUM_CORES-1:0]               core_done,
    output logic [NUM_CORES-1:0]               core_pass,
    output logic [NUM_CORES-1:0]               core_timeout,
    output logic [NUM_CORES-1:0]               core_done_pulse,
    output logic [NUM_CORES*CYCLE_BITS-1:0]    cycle_count,
    output logic [$clog2(NUM_CORES+1)-1:0]     finish_count,
    output logic                               all_done
);

    localparam int FC_W = $clog2(NUM_CORES + 1);

    logic [CYCLE_BITS-1:0] elapsed;
    logic [CYCLE_BITS-1:0] elapsed_inc;
    logic [MAX_CORES-1:0]  done_ext;

    // Saturating view of elapsed+1, shared by detection and timeout compare.
    assign elapsed_inc = (elapsed == '1) ? elapsed : elapsed + CYCLE_BITS'(1);
    assign done_ext    = MAX_CORES'(core_done);

    // Run clock: cleared by start, then counts every clock up to all-ones.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            elapsed <= '0;
        end else begin
            elapsed <= elapsed_inc;
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_completion_tracker #(
            .ADDRESS_BITS (ADDRESS_BITS),
            .DATA_WIDTH   (DATA_WIDTH),
            .CYCLE_BITS   (CYCLE_BITS),
            .DRAIN_CYCLES (DRAIN_CYCLES),
            .PASS_VALUE   (PASS_VALUE)
        ) u_tracker (
            .clock         (clock),
            .reset         (reset),
            .start         (start),
            .pc            (PC[i*ADDRESS_BITS +: ADDRESS_BITS]),
            .end_address   (end_address[i*ADDRESS_BITS +: ADDRESS_BITS]),
            .result_reg    (result_reg[i*DATA_WIDTH +: DATA_WIDTH]),
            .timeout_limit (timeout_limit),
            .elapsed_inc   (elapsed_inc),
            .done          (core_done[i]),
            .pass          (core_pass[i]),
            .timeout       (core_timeout[i]),
            .done_pulse    (core_done_pulse[i]),
            .cycle_count   (cycle_count[i*CYCLE_BITS +: CYCLE_BITS])
        );
    end

    // Aggregate status, registered one cycle behind core_done.
    always_ff @(posedge clock) begin
        if (reset) begin
            finish_count <= '0;
            all_done     <= 1'b0;
        end else begin
            finish_count <= FC_W'(popcount(done_ext));
            all_done     <= &core_done;
        end
    end

endmodule

// File: tb/tb_multicore_completion_monitor.sv
// Randomized and directed bench for multicore_completion_monitor with a run-level model.
module tb_multicore_completion_monitor;

    localparam int N   = 2;
    localparam int AB  = 32;
    localparam int DW  = 32;
    localparam int CB  = 32;
    localparam int D   = 50;
    localparam int FCW = $clog2(N + 1);
    localparam int INF = 1 << 30;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [N*AB-1:0]   PC;
    logic [N*AB-1:0]   end_address;
    logic [N*DW-1:0]   result_reg;
    logic [CB-1:0]     timeout_limit;
    logic [N-1:0]      core_done;
    logic [N-1:0]      core_pass;
    logic [N-1:0]      core_timeout;
    logic [N-1:0]      core_done_pulse;
    logic [N*CB-1:0]   cycle_count;
    logic [FCW-1:0]    finish_count;
    logic              all_done;

    int total = 0;
    int bad   = 0;

    // Scenario description and the expectations derived from it.
    logic [AB-1:0] ea [N];
    logic [DW-1:0] rv [N];
    int            m  [N];
    int            tlim;
    int            det_k  [N];
    int            done_k [N];
    int            exp_cc [N];
    bit            exp_to [N];
    bit            exp_ps [N];
    int            prev_cnt;

    always #5 clock = ~clock;

    multicore_completion_monitor #(
        .NUM_CORES    (N),
        .ADDRESS_BITS (AB),
        .DATA_WIDTH   (DW),
        .CYCLE_BITS   (CB),
        .DRAIN_CYCLES (D),
        .PASS_VALUE   ('0)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .PC              (PC),
        .end_address     (end_address),
        .result_reg      (result_reg),
        .timeout_limit   (timeout_limit),
        .core_done       (core_done),
        .core_pass       (core_pass),
        .core_timeout    (core_timeout),
        .core_done_pulse (core_done_pulse),
        .cycle_count     (cycle_count),
        .finish_count    (finish_count),
        .all_done        (all_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outcome of a run from its rules: match (<= limit wins) then drain, else timeout.
    task automatic plan();
        for (int i = 0; i < N; i++) begin
            if (m[i] != 0 && (tlim == 0 || m[i] <= tlim)) begin
                det_k[i] = m[i]; exp_cc[i] = m[i]; done_k[i] = m[i] + D;
                exp_to[i] = 1'b0; exp_ps[i] = (rv[i] == '0);
            end else if (tlim != 0) begin
                det_k[i] = tlim; exp_cc[i] = tlim; done_k[i] = tlim;
                exp_to[i] = 1'b1; exp_ps[i] = 1'b0;
            end else begin
                det_k[i] = INF; exp_cc[i] = 0; done_k[i] = INF;
                exp_to[i] = 1'b0; exp_ps[i] = 1'b0;
            end
        end
    endtask

    // Inputs seen at edge k after start: PC hits only at the planned edge
    // (and arbitrarily once the core has finished detecting), the graded
    // result value is present only on the sampling edge.
    task automatic drive(input int k);
        for (int i = 0; i < N; i++) begin
            PC[i*AB +: AB] = (k == m[i] || k > det_k[i]) ? ea[i] : (ea[i] ^ AB'(1));
            if (k == done_k[i]) result_reg[i*DW +: DW] = rv[i];
            else result_reg[i*DW +: DW] = (rv[i] == '0) ? DW'(1) : '0;
        end
    endtask

    task automatic check_cycle(input int k);
        int cnt;
        bit d;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            d = (k >= done_k[i]);
            cnt += int'(d);
            check($sformatf("done%0d k=%0d", i, k), 64'(core_done[i]), 64'(d));
            check($sformatf("pulse%0d k=%0d", i, k), 64'(core_done_pulse[i]), 64'(k == done_k[i]));
            check($sformatf("pass%0d k=%0d", i, k), 64'(core_pass[i]), 64'(d && exp_ps[i]));
            check($sformatf("timeout%0d k=%0d", i, k), 64'(core_timeout[i]), 64'(d && exp_to[i]));
            check($sformatf("cycle_count%0d k=%0d", i, k), 64'(cycle_count[i*CB +: CB]),
                  64'((k >= det_k[i]) ? exp_cc[i] : 0));
        end
        check($sformatf("finish_count k=%0d", k), 64'(finish_count), 64'(prev_cnt));
        check($sformatf("all_done k=%0d", k), 64'(all_done), 64'(prev_cnt == N));
        prev_cnt = cnt;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " done"}, 64'(core_done), 64'(0));
        check({tag, " pass"}, 64'(core_pass), 64'(0));
        check({tag, " timeout"}, 64'(core_timeout), 64'(0));
        check({tag, " pulse"}, 64'(core_done_pulse), 64'(0));
        check({tag, " cycle_count"}, 64'(cycle_count), 64'(0));
        check({tag, " finish_count"}, 64'(finish_count), 64'(0));
        check({tag, " all_done"}, 64'(all_done), 64'(0));
    endtask

    // One run: start edge (k=0) then len further edges, checked after each.
    task automatic scenario(input logic [AB-1:0] e0, input logic [AB-1:0] e1,
                            input int m0, input int m1, input int t,
                            input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                            input int len);
        int n;
        int maxd;
        ea[0] = e0; ea[1] = e1; m[0] = m0; m[1] = m1; rv[0] = r0; rv[1] = r1; tlim = t;
        plan();
        maxd = 0;
        for (int i = 0; i < N; i++)
            if (done_k[i] != INF && done_k[i] > maxd) maxd = done_k[i];
        n = (len >= 0) ? len : ((maxd == 0) ? 80 : maxd + 3);
        end_address = {ea[1], ea[0]};
        timeout_limit = CB'(tlim);
        for (int i = 0; i < N; i++) PC[i*AB +: AB] = ea[i] ^ AB'(1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_cycle(0);
        for (int k = 1; k <= n; k++) begin
            drive(k);
            @(posedge clock); #1;
            check_cycle(k);
        end
    endtask

    initial begin
        logic [AB-1:0] re0, re1;
        int rm0, rm1, rt, rlen, maxd;
        logic [DW-1:0] rr0, rr1;

        reset = 1'b1; start = 1'b0; PC = '0; end_address = '0;
        result_reg = '0; timeout_limit = '0; prev_cnt = 0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;

        // Both pass at 40/90.
        scenario(32'hB0, 32'h168, 40, 90, 0, '0, '0, -1);
        // Core1 fails on its sampling edge; restarted from DONE.
        scenario(32'hB0, 32'h168, 40, 90, 0, '0, 32'h5, -1);
        // Core1 never reaches its end address: timeout at 100.
        scenario(32'hB0, 32'h168, 30, 0, 100, '0, '0, -1);
        // Same end address, same match edge, one fails.
        scenario(32'h200, 32'h200, 60, 60, 0, '0, 32'h7, -1);
        // Match on the timeout edge wins; match on the first edge after start.
        scenario(32'h40, 32'h80, 100, 1, 100, '0, '0, -1);
        // Restart mid-run while core0 drains.
        scenario(32'h10, 32'h20, 20, 70, 0, '0, '0, 45);
        scenario(32'h10, 32'h20, 3, 7, 0, 32'h1, '0, -1);

        // Reset in the middle of DRAIN.
        scenario(32'h30, 32'h34, 20, 25, 0, '0, '0, 40);
        reset = 1'b1;
        @(posedge clock); #1;
        check_zero("mid-drain reset");
        // start together with reset must not launch a run.
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; reset = 1'b0;
        check_zero("start under reset");
        prev_cnt = 0;
        PC = end_address;
        result_reg = '0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clock); #1;
            if (k % 10 == 9) check_zero($sformatf("idle k=%0d", k));
        end
        scenario(32'h30, 32'h34, 5, 5, 0, '0, '0, -1);

        // Randomized runs, some aborted by an early restart.
        for (int r = 0; r < 16; r++) begin
            re0 = AB'($urandom); re1 = ($urandom_range(0, 3) == 0) ? re0 : AB'($urandom);
            rm0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120));
            rm1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120));
            rt  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 150));
            rr0 = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
            rr1 = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
            rlen = -1;
            if ($urandom_range(0, 4) == 0) begin
                maxd = (rt != 0) ? rt : 120;
                rlen = int'($urandom_range(1, maxd));
            end
            scenario(re0, re1, rm0, rm1, rt, rr0, rr1, rlen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
